// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read port to valid/ready burst stream through a 2-entry skid buffer
module fifo_rd_stream #(
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 4
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdata,
  output logic              ren,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [1:0]        occ
);
  localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [1:0] ZERO = 2'd0;
  localparam logic [1:0] ONE  = 2'd1;
  localparam logic [1:0] TWO  = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  logic [DATA_W-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic pend, pop;
  logic [2:0] credit;
  logic [1:0] slot;
  assign pop = m_valid & m_ready;
  // words held plus words in flight, after this cycle's pop leaves
  assign credit = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
  assign ren = rrst & ~empty & (credit < 3'd2);
  assign slot = occ - {1'b0, pop};
  assign m_valid = occ != ZERO;
  assign m_data = head;
  assign m_last = m_valid & (cnt == LAST);
  always_ff @(posedge rclk or negedge rrst)
    if (!rrst) begin
      occ  <= ZERO;
      pend <= 1'b0;
      cnt  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      occ  <= occ + {1'b0, pend} - {1'b0, pop};
      pend <= ren;
      if (pop) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      head <= (pend && slot == ZERO) ? rdata : pop ? tail : head;
      if (pend && slot == ONE) tail <= rdata;
    end
  assert property (@(posedge rclk) disable iff (!rrst) !(pend && occ == TWO && !pop));
endmodule
